// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and sizing helpers for the stopwatch control block.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } sw_state_e;

  function automatic int calc_tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Width of a counter that must hold 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, one-cycle press pulse.
module btn_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press_p
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          lvl_q, lvl_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count only while the synchronized sample disagrees with the accepted level;
  // any agreeing sample restarts the count.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d   = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_p = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear sequencer: tick prescaler, counter enable/clear,
// and display source selection between live count and frozen lap value.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic [7:0] count_bcd,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [7:0] disp_bcd,
  output logic [1:0] state,
  output logic       running
);

  localparam int TICK_DIV = calc_tick_div(CLK_HZ, TICK_HZ);
  localparam int PW       = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic start_p, lap_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn_start),
    .press_p (start_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn_lap),
    .press_p (lap_p)
  );

  sw_state_e     state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    lap_q, lap_d;
  logic [7:0]    disp_q, disp_d;
  logic          en_q, en_d;
  logic          clr_q, clr_d;
  logic          run_now;

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    clr_d   = 1'b0;
    run_now = (state_q == ST_RUN) || (state_q == ST_LAP);

    // start_p is tested first everywhere, so it wins over a same-cycle lap_p.
    case (state_q)
      ST_IDLE: begin
        if (start_p) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_p) begin
          state_d = ST_PAUSE;
        end else if (lap_p) begin
          state_d = ST_LAP;
          lap_d   = count_bcd;
        end
      end
      ST_LAP: begin
        if (start_p)    state_d = ST_PAUSE;
        else if (lap_p) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (start_p) begin
          state_d = ST_RUN;
        end else if (lap_p) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    en_d = run_now && (pre_q == PRE_LAST);

    // PAUSE holds the prescaler so a resume keeps the partial tick.
    if ((state_q == ST_IDLE) || clr_q) pre_d = '0;
    else if (run_now)                  pre_d = en_d ? '0 : pre_q + 1'b1;
    else                               pre_d = pre_q;

    disp_d = (state_q == ST_LAP) ? lap_q : count_bcd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      lap_q   <= 8'h00;
      disp_q  <= 8'h00;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      lap_q   <= lap_d;
      disp_q  <= disp_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
    end
  end

  assign cnt_en   = en_q;
  assign cnt_clr  = clr_q;
  assign disp_bcd = disp_q;
  assign state    = state_q;
  assign running  = (state_q == ST_RUN) || (state_q == ST_LAP);

endmodule
